// File: rtl/pool_pkg.sv
// Shared definitions for the max-pooling window unit: number formats, FSM
// states, the order-preserving compare key and the argmax index width.
package pool_pkg;

   localparam int NUM_FMT_FIXED = 0;
   localparam int NUM_FMT_HALF  = 1;
   localparam int KEY_MAX_W     = 64;

   typedef enum logic {
      ST_FIRST,
      ST_ACCUM
   } pool_state_e;

   function automatic int idx_width(input int window);
      return (window <= 2) ? 1 : $clog2(window);
   endfunction

   // Maps a w-bit element to an unsigned key whose ordering matches the
   // numeric ordering of the format; upper bits beyond w are always zero.
   function automatic logic [KEY_MAX_W-1:0] cmp_key(input logic [KEY_MAX_W-1:0] value,
                                                    input int w, input int fmt);
      logic [KEY_MAX_W-1:0] msb;
      logic [KEY_MAX_W-1:0] mask;
      msb  = KEY_MAX_W'(1) << (w - 1);
      mask = (msb << 1) - KEY_MAX_W'(1);
      if (fmt == NUM_FMT_HALF) begin
         if ((value & msb) != '0) return ~value & mask;
         return value | msb;
      end
      return (value ^ msb) & mask;
   endfunction

endpackage

// File: rtl/pool_lane.sv
// One lane of the pooling window: running maximum, its beat index, and the
// compare that folds the current beat into the result.
module pool_lane
   import pool_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int IDX_W   = 2,
   parameter int NUM_FMT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              beat,
   input  logic              first,
   input  logic [IDX_W-1:0]  cnt,
   input  logic [DATA_W-1:0] in_val,
   output logic [DATA_W-1:0] res_data,
   output logic [IDX_W-1:0]  res_idx
);

   logic [DATA_W-1:0]    acc_q, acc_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [KEY_MAX_W-1:0] key_in, key_acc;
   logic                 gt;

   // res_* already includes the current beat so the closing beat's own
   // comparison reaches the output register in the same cycle.
   always_comb begin
      key_in   = cmp_key(KEY_MAX_W'(in_val), DATA_W, NUM_FMT);
      key_acc  = cmp_key(KEY_MAX_W'(acc_q), DATA_W, NUM_FMT);
      gt       = key_in > key_acc;
      res_data = acc_q;
      res_idx  = idx_q;
      if (first) begin
         res_data = in_val;
         res_idx  = '0;
      end else if (gt) begin
         res_data = in_val;
         res_idx  = cnt;
      end
      acc_d = beat ? res_data : acc_q;
      idx_d = beat ? res_idx  : idx_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
         idx_q <= '0;
      end else begin
         acc_q <= acc_d;
         idx_q <= idx_d;
      end
   end

endmodule

// File: rtl/max_pool_window.sv
// Streaming max-pool reduction: WINDOW beats per window, LANES channels in
// parallel, emitting per-lane maximum, argmax beat index and a short flag.
module max_pool_window
   import pool_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int WINDOW  = 4,
   parameter int LANES   = 2,
   parameter int NUM_FMT = 1,
   parameter int IDX_W   = idx_width(WINDOW)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [LANES*DATA_W-1:0] in_data,
   input  logic                    in_last,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [LANES*DATA_W-1:0] out_data,
   output logic [LANES*IDX_W-1:0]  out_index,
   output logic                    out_short
);

   pool_state_e                    state_q, state_d;
   logic [IDX_W-1:0]               cnt_q, cnt_d;
   logic                           out_valid_q, out_valid_d;
   logic                           out_short_q, out_short_d;
   logic [LANES-1:0][DATA_W-1:0]   out_data_q, out_data_d;
   logic [LANES-1:0][IDX_W-1:0]    out_index_q, out_index_d;
   logic [LANES-1:0][DATA_W-1:0]   in_lanes, lane_max;
   logic [LANES-1:0][IDX_W-1:0]    lane_idx;
   logic                           accept, first, win_full, close;

   assign in_lanes = in_data;

   always_comb begin
      in_ready = !out_valid_q || out_ready;
      accept   = in_valid && in_ready;
      first    = (state_q == ST_FIRST);
      win_full = !first && (cnt_q == IDX_W'(WINDOW - 1));
      close    = accept && (in_last || win_full);

      state_d     = state_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      out_short_d = out_short_q;
      out_data_d  = out_data_q;
      out_index_d = out_index_q;

      if (accept) begin
         if (close) begin
            state_d = ST_FIRST;
            cnt_d   = '0;
         end else begin
            state_d = ST_ACCUM;
            cnt_d   = cnt_q + IDX_W'(1);
         end
      end

      // A new result overwrites a just-consumed one; otherwise hold until taken.
      if (close) begin
         out_valid_d = 1'b1;
         out_data_d  = lane_max;
         out_index_d = lane_idx;
         out_short_d = !win_full;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_FIRST;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_short_q <= 1'b0;
         out_data_q  <= '0;
         out_index_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_short_q <= out_short_d;
         out_data_q  <= out_data_d;
         out_index_q <= out_index_d;
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      pool_lane #(
         .DATA_W  (DATA_W),
         .IDX_W   (IDX_W),
         .NUM_FMT (NUM_FMT)
      ) u_lane (
         .clk      (clk),
         .rst      (rst),
         .beat     (accept),
         .first    (first),
         .cnt      (cnt_q),
         .in_val   (in_lanes[g]),
         .res_data (lane_max[g]),
         .res_idx  (lane_idx[g])
      );
   end

   assign out_valid = out_valid_q;
   assign out_short = out_short_q;
   assign out_data  = out_data_q;
   assign out_index = out_index_q;

endmodule

// File: tb/tb_max_pool_window.sv
// Bench for max_pool_window: a half-float and a fixed-point instance share
// one stimulus stream and are scored against a window-level reference model.
module tb_max_pool_window;

   localparam int DW = 16;
   localparam int W  = 4;
   localparam int L  = 2;
   localparam int IW = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
   logic [L*DW-1:0] in_data = '0;

   logic            in_ready_h, out_valid_h, out_short_h;
   logic [L*DW-1:0] out_data_h;
   logic [L*IW-1:0] out_index_h;
   logic            in_ready_f, out_valid_f, out_short_f;
   logic [L*DW-1:0] out_data_f;
   logic [L*IW-1:0] out_index_f;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [L*DW-1:0] data;
      logic [L*IW-1:0] idx;
      logic            short_w;
   } res_t;

   res_t            exp_h[$];
   res_t            exp_f[$];
   logic [L*DW-1:0] win[$];
   logic [DW-1:0]   pool[4] = '{16'h0000, 16'h8000, 16'h7FFF, 16'h3C00};

   always #5 clk = ~clk;

   max_pool_window #(.DATA_W(DW), .WINDOW(W), .LANES(L), .NUM_FMT(1)) dut_h (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_h),
      .in_data(in_data), .in_last(in_last), .out_valid(out_valid_h),
      .out_ready(out_ready), .out_data(out_data_h), .out_index(out_index_h),
      .out_short(out_short_h));

   max_pool_window #(.DATA_W(DW), .WINDOW(W), .LANES(L), .NUM_FMT(0)) dut_f (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_f),
      .in_data(in_data), .in_last(in_last), .out_valid(out_valid_f),
      .out_ready(out_ready), .out_data(out_data_f), .out_index(out_index_f),
      .out_short(out_short_f));

   // Numeric rank: signed integer, or half-float ordered by raw bits.
   function automatic int rank(input logic [DW-1:0] v, input int fmt);
      if (fmt == 0) return int'($signed(v));
      if (v[DW-1]) return 32767 - int'(v[DW-2:0]);
      return 32768 + int'(v);
   endfunction

   function automatic res_t reference(input int fmt);
      res_t r;
      logic [L*DW-1:0] eb, ec;
      int best;
      r.data = '0;
      r.idx  = '0;
      for (int l = 0; l < L; l++) begin
         best = 0;
         for (int b = 1; b < win.size(); b++) begin
            eb = win[b];
            ec = win[best];
            if (rank(eb[l*DW +: DW], fmt) > rank(ec[l*DW +: DW], fmt)) best = b;
         end
         ec = win[best];
         r.data[l*DW +: DW] = ec[l*DW +: DW];
         r.idx[l*IW +: IW]  = IW'(best);
      end
      r.short_w = (win.size() < W);
      return r;
   endfunction

   function automatic logic [DW-1:0] rand_lane();
      if ($urandom_range(0, 2) == 0) return pool[$urandom_range(0, 3)];
      return 16'($urandom);
   endfunction

   res_t sb_e;
   always @(negedge clk) begin
      if (rst) begin
         win.delete();
         exp_h.delete();
         exp_f.delete();
      end else begin
         if (out_valid_h && out_ready) begin
            checks++;
            if (exp_h.size() == 0) begin
               failures++;
               $display("FAIL sb_half unexpected result data=%h", out_data_h);
            end else begin
               sb_e = exp_h.pop_front();
               if ({out_data_h, out_index_h, out_short_h} !== {sb_e.data, sb_e.idx, sb_e.short_w}) begin
                  failures++;
                  $display("FAIL sb_half got data=%h idx=%h short=%b want data=%h idx=%h short=%b",
                           out_data_h, out_index_h, out_short_h, sb_e.data, sb_e.idx, sb_e.short_w);
               end
            end
         end
         if (out_valid_f && out_ready) begin
            checks++;
            if (exp_f.size() == 0) begin
               failures++;
               $display("FAIL sb_fixed unexpected result data=%h", out_data_f);
            end else begin
               sb_e = exp_f.pop_front();
               if ({out_data_f, out_index_f, out_short_f} !== {sb_e.data, sb_e.idx, sb_e.short_w}) begin
                  failures++;
                  $display("FAIL sb_fixed got data=%h idx=%h short=%b want data=%h idx=%h short=%b",
                           out_data_f, out_index_f, out_short_f, sb_e.data, sb_e.idx, sb_e.short_w);
               end
            end
         end
         if (in_valid && in_ready_h) begin
            win.push_back(in_data);
            if (in_last || win.size() == W) begin
               exp_h.push_back(reference(1));
               exp_f.push_back(reference(0));
               win.delete();
            end
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = '0;
   endtask

   // Presents one beat until accepted; reports out_valid seen on the
   // accepting cycle and how many cycles it took.
   task automatic send_beat(input logic [L*DW-1:0] d, input logic last,
                            output logic ov, output int cyc);
      logic acc;
      acc = 1'b0;
      ov  = 1'b0;
      cyc = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      for (int k = 0; k < 50 && !acc; k++) begin
         @(negedge clk);
         ov  = out_valid_h;
         acc = in_ready_h;
         cyc++;
         @(posedge clk);
         #1;
         if (!acc) out_ready = 1'b1;
      end
      if (!acc) begin
         checks++;
         failures++;
         $display("FAIL send_beat timeout");
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      out_ready = 1'b1;
      cycles(3);
      @(negedge clk);
      checks++;
      if ({out_valid_h, out_data_h, out_index_h, out_short_h} !== 38'h0) begin
         failures++;
         $display("FAIL reset_half got v=%b d=%h i=%h s=%b want zeros", out_valid_h, out_data_h, out_index_h, out_short_h);
      end
      checks++;
      if ({out_valid_f, out_data_f, out_index_f, out_short_f} !== 38'h0) begin
         failures++;
         $display("FAIL reset_fixed got v=%b d=%h i=%h s=%b want zeros", out_valid_f, out_data_f, out_index_f, out_short_f);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready_h !== 1'b1 || out_valid_h !== 1'b0) begin
         failures++;
         $display("FAIL reset_release got in_ready=%b out_valid=%b want 1 0", in_ready_h, out_valid_h);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_half_fmt();
      logic [DW-1:0] l0[4] = '{16'h3C00, 16'hC000, 16'h4000, 16'h3C00};
      logic [DW-1:0] l1[4] = '{16'h8000, 16'h0000, 16'h8000, 16'h0000};
      logic ov;
      int cyc;
      for (int i = 0; i < 4; i++) begin
         send_beat({l1[i], l0[i]}, 1'b0, ov, cyc);
         if (i == 3) begin
            checks++;
            if (ov !== 1'b0) begin
               failures++;
               $display("FAIL half_latency_early got out_valid=%b want 0", ov);
            end
         end
      end
      idle();
      @(negedge clk);
      checks++;
      if (out_valid_h !== 1'b1 || out_data_h !== 32'h0000_4000 || out_index_h !== {2'd1, 2'd2} || out_short_h !== 1'b0) begin
         failures++;
         $display("FAIL half_window got v=%b d=%h i=%h s=%b want 1 00004000 6 0",
                  out_valid_h, out_data_h, out_index_h, out_short_h);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_fixed_tie();
      logic [DW-1:0] l0[4] = '{16'hFFFF, 16'h7FFF, 16'h7FFF, 16'h8000};
      logic ov;
      int cyc;
      for (int i = 0; i < 4; i++) send_beat({rand_lane(), l0[i]}, 1'b0, ov, cyc);
      idle();
      @(negedge clk);
      checks++;
      if (out_valid_f !== 1'b1 || out_data_f[15:0] !== 16'h7FFF || out_index_f[1:0] !== 2'd1) begin
         failures++;
         $display("FAIL fixed_tie got v=%b d=%h i=%0d want 1 7fff 1", out_valid_f, out_data_f[15:0], out_index_f[1:0]);
      end
      checks++;
      if (out_data_h[15:0] !== 16'h7FFF || out_index_h[1:0] !== 2'd1) begin
         failures++;
         $display("FAIL half_nan_tie got d=%h i=%0d want 7fff 1", out_data_h[15:0], out_index_h[1:0]);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_short();
      logic ov;
      int cyc;
      logic [DW-1:0] nx[4] = '{16'h0100, 16'h0001, 16'h0001, 16'h0001};
      send_beat({rand_lane(), 16'h0005}, 1'b0, ov, cyc);
      send_beat({rand_lane(), 16'h0009}, 1'b1, ov, cyc);
      idle();
      @(negedge clk);
      checks++;
      if (out_valid_h !== 1'b1 || out_data_h[15:0] !== 16'h0009 || out_index_h[1:0] !== 2'd1 || out_short_h !== 1'b1) begin
         failures++;
         $display("FAIL short_half got v=%b d=%h i=%0d s=%b want 1 0009 1 1", out_valid_h, out_data_h[15:0], out_index_h[1:0], out_short_h);
      end
      checks++;
      if (out_data_f[15:0] !== 16'h0009 || out_index_f[1:0] !== 2'd1 || out_short_f !== 1'b1) begin
         failures++;
         $display("FAIL short_fixed got d=%h i=%0d s=%b want 0009 1 1", out_data_f[15:0], out_index_f[1:0], out_short_f);
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) send_beat({rand_lane(), nx[i]}, 1'b0, ov, cyc);
      idle();
      @(negedge clk);
      checks++;
      if (out_data_h[15:0] !== 16'h0100 || out_index_h[1:0] !== 2'd0 || out_short_h !== 1'b0 ||
          out_data_f[15:0] !== 16'h0100 || out_index_f[1:0] !== 2'd0 || out_short_f !== 1'b0) begin
         failures++;
         $display("FAIL after_short got h=%h/%0d/%b f=%h/%0d/%b want 0100/0/0", out_data_h[15:0], out_index_h[1:0],
                  out_short_h, out_data_f[15:0], out_index_f[1:0], out_short_f);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_backpressure();
      logic ov;
      int cyc;
      logic [L*DW-1:0] cap_d;
      logic [L*IW-1:0] cap_i;
      logic cap_s;
      cap_d = '0;
      cap_i = '0;
      cap_s = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) send_beat({rand_lane(), rand_lane()}, 1'b0, ov, cyc);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_last   = 1'b0;
      in_data   = {rand_lane(), rand_lane()};
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++;
         if (in_ready_h !== 1'b0 || in_ready_f !== 1'b0 || out_valid_h !== 1'b1) begin
            failures++;
            $display("FAIL stall_ready cycle %0d got in_ready=%b/%b out_valid=%b want 0/0 1", c, in_ready_h, in_ready_f, out_valid_h);
         end
         if (c == 0) begin
            cap_d = out_data_h;
            cap_i = out_index_h;
            cap_s = out_short_h;
         end else begin
            checks++;
            if ({out_data_h, out_index_h, out_short_h} !== {cap_d, cap_i, cap_s}) begin
               failures++;
               $display("FAIL stall_hold cycle %0d got %h/%h/%b want %h/%h/%b", c, out_data_h, out_index_h, out_short_h, cap_d, cap_i, cap_s);
            end
         end
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready_h !== 1'b1) begin
         failures++;
         $display("FAIL release_accept got in_ready=%b want 1", in_ready_h);
      end
      @(posedge clk);
      #1;
      for (int i = 1; i < 4; i++) send_beat({rand_lane(), rand_lane()}, 1'b0, ov, cyc);
      idle();
      cycles(2);
   endtask

   task automatic test_back_to_back();
      logic ov;
      int cyc;
      out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         send_beat({rand_lane(), rand_lane()}, 1'b0, ov, cyc);
         checks++;
         if (cyc !== 1) begin
            failures++;
            $display("FAIL b2b_ready beat %0d took %0d cycles want 1", i, cyc);
         end
         checks++;
         if (ov !== (i > 0 && i % 4 == 0)) begin
            failures++;
            $display("FAIL b2b_valid beat %0d got out_valid=%b want %b", i, ov, (i > 0 && i % 4 == 0));
         end
      end
      idle();
      @(negedge clk);
      checks++;
      if (out_valid_h !== 1'b1) begin
         failures++;
         $display("FAIL b2b_last got out_valid=%b want 1", out_valid_h);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid();
      logic ov;
      int cyc;
      logic [DW-1:0] l0[4] = '{16'h0001, 16'h0003, 16'h0002, 16'h0000};
      logic [DW-1:0] l1[4] = '{16'h0002, 16'h0002, 16'h0004, 16'h0001};
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) send_beat({rand_lane(), rand_lane()}, 1'b0, ov, cyc);
      idle();
      out_ready = 1'b0;
      checks++;
      if (out_valid_h !== 1'b1) begin
         failures++;
         $display("FAIL pre_reset_valid got %b want 1", out_valid_h);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (out_valid_h !== 1'b0 || out_valid_f !== 1'b0) begin
         failures++;
         $display("FAIL async_reset got out_valid=%b/%b want 0/0", out_valid_h, out_valid_f);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) send_beat({16'h7000, 16'h7000}, 1'b0, ov, cyc);
      idle();
      rst = 1'b1;
      cycles(1);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) send_beat({l1[i], l0[i]}, 1'b0, ov, cyc);
      idle();
      @(negedge clk);
      checks++;
      if (out_valid_h !== 1'b1 || out_data_h !== 32'h0004_0003 || out_index_h !== {2'd2, 2'd1} || out_short_h !== 1'b0) begin
         failures++;
         $display("FAIL post_reset_half got v=%b d=%h i=%h s=%b want 1 00040003 9 0", out_valid_h, out_data_h, out_index_h, out_short_h);
      end
      checks++;
      if (out_valid_f !== 1'b1 || out_data_f !== 32'h0004_0003 || out_index_f !== {2'd2, 2'd1} || out_short_f !== 1'b0) begin
         failures++;
         $display("FAIL post_reset_fixed got v=%b d=%h i=%h s=%b want 1 00040003 9 0", out_valid_f, out_data_f, out_index_f, out_short_f);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_random();
      logic ov;
      int cyc;
      for (int i = 0; i < 200; i++) begin
         out_ready = ($urandom_range(0, 3) != 0);
         send_beat({rand_lane(), rand_lane()}, ($urandom_range(0, 5) == 0), ov, cyc);
      end
      out_ready = 1'b1;
      send_beat({rand_lane(), rand_lane()}, 1'b1, ov, cyc);
      idle();
      cycles(4);
      checks++;
      if (exp_h.size() != 0 || exp_f.size() != 0 || win.size() != 0) begin
         failures++;
         $display("FAIL drain got pending half=%0d fixed=%0d partial=%0d want 0 0 0", exp_h.size(), exp_f.size(), win.size());
      end
   endtask

   initial begin
      test_reset();
      test_half_fmt();
      test_fixed_tie();
      test_short();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
